// File: rtl/player_life_ctrl.sv
// rtl/player_life_ctrl.sv - player lives, death/respawn window, invulnerability blink and game-over
module player_life_ctrl #(
  parameter int INIT_LIVES  = 3,
  parameter int DEATH_TICKS = 16,
  parameter int INV_TICKS   = 48,
  parameter int BLINK_HALF  = 4
) (
  input  logic       clk22,
  input  logic       rst,
  input  logic       gamestart,
  input  logic       shot,
  output logic [2:0] lives,
  output logic       alive,
  output logic       invuln,
  output logic       visible,
  output logic       hit,
  output logic       gameover
);

  // Timer must hold the longer of the two countdown loads without wrapping.
  localparam int TMAX = (DEATH_TICKS > INV_TICKS) ? DEATH_TICKS : INV_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIVE  = 3'd1,
    S_DEAD   = 3'd2,
    S_INVULN = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t          state_q, state_n;
  logic [2:0]      lives_q, lives_n;
  logic [TW-1:0]   timer_q, timer_n;
  logic            blink_q, blink_n;
  logic [BW-1:0]   bcnt_q, bcnt_n;
  logic            hit_q, hit_n;

  // State, counters, lives and the hit pulse are all registered here.
  always_ff @(posedge clk22 or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lives_q <= 3'd0;
      timer_q <= '0;
      blink_q <= 1'b1;
      bcnt_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      lives_q <= lives_n;
      timer_q <= timer_n;
      blink_q <= blink_n;
      bcnt_q  <= bcnt_n;
      hit_q   <= hit_n;
    end
  end

  // Next-state logic; gamestart overrides everything and swallows any concurrent shot.
  always_comb begin
    state_n = state_q;
    lives_n = lives_q;
    timer_n = timer_q;
    blink_n = blink_q;
    bcnt_n  = bcnt_q;
    hit_n   = 1'b0;
    if (gamestart) begin
      state_n = S_ALIVE;
      lives_n = 3'(INIT_LIVES);
      timer_n = '0;
      blink_n = 1'b1;
      bcnt_n  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_n = S_IDLE;
        end
        S_ALIVE: begin
          if (shot) begin
            hit_n = 1'b1;
            // Last life lost goes straight to game-over; lives can never go below zero.
            if (lives_q <= 3'd1) begin
              state_n = S_OVER;
              lives_n = 3'd0;
            end else begin
              state_n = S_DEAD;
              lives_n = lives_q - 3'd1;
              timer_n = TW'(DEATH_TICKS - 1);
            end
          end
        end
        S_DEAD: begin
          if (timer_q == '0) begin
            state_n = S_INVULN;
            timer_n = TW'(INV_TICKS - 1);
            blink_n = 1'b1;
            bcnt_n  = '0;
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
        S_INVULN: begin
          if (timer_q == '0) begin
            state_n = S_ALIVE;
          end else begin
            timer_n = timer_q - 1'b1;
          end
          // Blink phase flips after every BLINK_HALF cycles spent in INVULN.
          if (bcnt_q == BW'(BLINK_HALF - 1)) begin
            blink_n = ~blink_q;
            bcnt_n  = '0;
          end else begin
            bcnt_n = bcnt_q + 1'b1;
          end
        end
        S_OVER: begin
          lives_n = 3'd0;
        end
        default: begin
          state_n = S_IDLE;
          lives_n = 3'd0;
          timer_n = '0;
        end
      endcase
    end
  end

  // Output decode purely from registered state, so no input-to-output paths exist.
  always_comb begin
    lives    = lives_q;
    hit      = hit_q;
    alive    = (state_q == S_ALIVE) || (state_q == S_INVULN);
    invuln   = (state_q == S_INVULN);
    gameover = (state_q == S_OVER);
    visible  = 1'b0;
    if (state_q == S_ALIVE) begin
      visible = 1'b1;
    end else if (state_q == S_INVULN) begin
      visible = blink_q;
    end
  end

endmodule

// File: doc/player_life_ctrl.md
Name: player_life_ctrl

Overview:
- Downstream consumer of the enemy-bullet stage's `shot` hit flag.
- Converts raw hit flags into gameplay state: remaining lives, a death/respawn window, post-respawn invulnerability with sprite blink, and game-over.
- Outputs drive the sprite renderer (`visible`), the HUD (`lives`) and the top-level game FSM (`gameover`).

Parameters:
- INIT_LIVES, 3, lives loaded on gamestart; legal range 1..7.
- DEATH_TICKS, 16, clk22 cycles spent in DEAD (death animation) before respawn.
- INV_TICKS, 48, clk22 cycles of invulnerability after respawn.
- BLINK_HALF, 4, clk22 cycles per half-period of the invulnerability blink.

Ports:
- clk22  input  1  game tick clock; shared with the bullet stage.
- rst  input  1  asynchronous, active-low reset.
- gamestart  input  1  synchronous start/restart request, level-sampled each edge.
- shot  input  1  hit flag from the enemy-bullet stage; may stay high on consecutive cycles.
- lives  output  3  remaining lives.
- alive  output  1  high in ALIVE and INVULN.
- invuln  output  1  high in INVULN only.
- visible  output  1  sprite enable for the renderer.
- hit  output  1  one-cycle pulse on an accepted hit (sound/FX trigger).
- gameover  output  1  high in OVER.

Behaviour:
- All outputs are registered, decoded from state, counters and `lives`.

States:
- IDLE: waiting for gamestart.
- ALIVE: normal play.
- DEAD: death animation.
- INVULN: respawn protection.
- OVER: game over.

Reset (rst=0, async):
- state=IDLE, lives=0, timer=0, blink phase=1.
- Outputs: alive=0, invuln=0, visible=0, hit=0, gameover=0.

Priority on each edge: rst > gamestart > state logic.

gamestart=1, from any state:
- Next state ALIVE, lives=INIT_LIVES, timer=0.
- hit=0; any concurrent shot is ignored.

IDLE:
- Holds; shot is ignored.

ALIVE:
- shot=1 is accepted: hit=1 for exactly one cycle, lives=lives-1.
- If the old lives value was 1 → OVER (lives=0).
- Otherwise → DEAD with timer=DEATH_TICKS-1.
- shot=0: stay in ALIVE.

DEAD:
- timer decrements each cycle; shot is ignored.
- At timer=0 → INVULN with timer=INV_TICKS-1 and blink phase=1.
- Duration is exactly DEATH_TICKS cycles.

INVULN:
- shot is ignored; hit stays 0.
- timer decrements each cycle; at timer=0 → ALIVE. Duration is exactly INV_TICKS cycles.
- Blink phase toggles every BLINK_HALF cycles, counted from INVULN entry.

OVER:
- Holds with lives=0 until gamestart.

Outputs per state:
- visible: 1 in ALIVE; blink phase in INVULN; 0 in IDLE, DEAD and OVER.
- alive: 1 in ALIVE and INVULN.
- gameover: 1 only in OVER.

Timing and arithmetic rules:
- Hit latency: shot sampled high at edge N → hit=1, lives updated and state changed, all visible after edge N.
- A shot held high for k cycles costs exactly one life, because DEAD ignores shot.
- shot still high on the first ALIVE cycle after INVULN counts as a new hit.
- lives never underflows: decrement happens only from ALIVE with lives≥1, and lives=0 is reachable only in OVER.
- Timers are wide enough for max(DEATH_TICKS, INV_TICKS)-1 and never wrap.
- Reset asserted mid-DEAD or mid-INVULN aborts the state immediately, with no residual pulse after release.
- gamestart held high keeps the block in ALIVE with full lives and blocks all hits.

Test Plan:
- Reset then gamestart for 1 cycle → lives=3, alive=1, visible=1, gameover=0; shot pulses while in IDLE beforehand cause no change.
- One-cycle shot in ALIVE → next cycle hit=1 (single cycle), lives=2, state DEAD with visible=0 for 16 cycles, then invuln=1 for 48 cycles, then ALIVE.
- In INVULN, watch visible and apply shot for 10 cycles → visible toggles every 4 cycles starting high; lives stays 2, no hit pulse.
- shot held high for 5 cycles in ALIVE → exactly one hit pulse and lives decrements by 1 only.
- Three separate hits with INIT_LIVES=3 → after the third, lives=0, gameover=1, alive=0, visible=0; further shots have no effect; gamestart restores lives=3 and ALIVE.
- Assert rst mid-DEAD (timer=7) → outputs go to reset values immediately, without waiting for a clock; after release the block stays IDLE until gamestart.
